// File: rtl/dcache_sram_nway.sv
// N-way set-associative tag/data store with true-LRU replacement, per-byte CPU write merge
// and a one-set-per-cycle invalidate sweep. Lookup is combinational; the response is registered.
module dcache_sram_nway #(
    parameter int NUM_WAYS = 4,
    parameter int SET_BITS = 4,
    parameter int TAG_W    = 25,
    parameter int LINE_W   = 256,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int NUM_SETS = 2 ** SET_BITS,
    localparam int BE_W     = LINE_W / 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                write_i,
    input  logic                fill_i,
    input  logic [SET_BITS-1:0] addr_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [LINE_W-1:0]   data_i,
    input  logic [BE_W-1:0]     be_i,
    input  logic                inval_i,
    output logic                busy_o,
    output logic                resp_valid_o,
    output logic                hit_o,
    output logic [WAY_W-1:0]    way_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [LINE_W-1:0]   data_o,
    output logic                dirty_o
);

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e                state_q, state_d;
    logic [SET_BITS-1:0]   sweepIdx_q, sweepIdx_d;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [TAG_W-1:0]      tagArr_q  [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]     dataArr_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]      age_q     [NUM_SETS][NUM_WAYS];

    logic                  respValid_q, hit_q, dirtyOut_q;
    logic [WAY_W-1:0]      way_q;
    logic [TAG_W-1:0]      tagOut_q;
    logic [LINE_W-1:0]     dataOut_q;

    logic                  req, hit, invFound, doTouch, cpuWriteHit;
    logic [NUM_WAYS-1:0]   hitVec;
    logic [WAY_W-1:0]      hitWay, invWay, lruWay, tgtWay;
    logic [LINE_W-1:0]     oldLine, mergedLine;
    logic [WAY_W-1:0]      newAge [NUM_WAYS];

    assign req = enable_i && (state_q == IDLE);

    // Tag compare, victim choice (lowest invalid way, else the oldest) and the LRU touch result.
    always_comb begin
        hitVec   = '0;
        hitWay   = '0;
        invFound = 1'b0;
        invWay   = '0;
        lruWay   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[addr_i][w] && (tagArr_q[addr_i][w] == tag_i)) begin
                hitVec[w] = 1'b1;
                hitWay    = WAY_W'(w);
            end
            if (!valid_q[addr_i][w]) begin
                invFound = 1'b1;
                invWay   = WAY_W'(w);
            end
            if (age_q[addr_i][w] == WAY_W'(NUM_WAYS - 1)) begin
                lruWay = WAY_W'(w);
            end
        end
        hit         = |hitVec;
        tgtWay      = hit ? hitWay : (invFound ? invWay : lruWay);
        doTouch     = req && (hit || (write_i && fill_i));
        cpuWriteHit = req && hit && write_i && !fill_i;
        oldLine     = dataArr_q[addr_i][tgtWay];
        for (int b = 0; b < BE_W; b++) begin
            mergedLine[b*8 +: 8] = be_i[b] ? data_i[b*8 +: 8] : oldLine[b*8 +: 8];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            newAge[w] = (age_q[addr_i][w] < age_q[addr_i][tgtWay]) ? age_q[addr_i][w] + 1'b1
                                                                  : age_q[addr_i][w];
        end
        newAge[tgtWay] = '0;
    end

    always_comb begin
        state_d    = state_q;
        sweepIdx_d = sweepIdx_q;
        case (state_q)
            IDLE: begin
                if (inval_i) begin
                    state_d    = SWEEP;
                    sweepIdx_d = '0;
                end
            end
            SWEEP: begin
                sweepIdx_d = sweepIdx_q + 1'b1;
                if (sweepIdx_q == SET_BITS'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sweepIdx_q <= '0;
        end else begin
            state_q    <= state_d;
            sweepIdx_q <= sweepIdx_d;
        end
    end

    // Requests are blocked while sweeping, so the sweep and an access never touch the arrays together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tagArr_q[s][w]  <= '0;
                    dataArr_q[s][w] <= '0;
                    age_q[s][w]     <= WAY_W'(w);
                end
            end
        end else begin
            if (state_q == SWEEP) begin
                valid_q[sweepIdx_q] <= '0;
                dirty_q[sweepIdx_q] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[sweepIdx_q][w] <= WAY_W'(w);
                end
            end
            if (doTouch) begin
                age_q[addr_i] <= newAge;
                if (write_i && fill_i) begin
                    tagArr_q[addr_i][tgtWay]  <= tag_i;
                    dataArr_q[addr_i][tgtWay] <= data_i;
                    valid_q[addr_i][tgtWay]   <= 1'b1;
                    dirty_q[addr_i][tgtWay]   <= 1'b0;
                end else if (write_i) begin
                    dataArr_q[addr_i][tgtWay] <= mergedLine;
                    dirty_q[addr_i][tgtWay]   <= 1'b1;
                end
            end
        end
    end

    // dirty_o reports the pre-access bit so the controller knows whether the victim needs write-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            respValid_q <= 1'b0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            tagOut_q    <= '0;
            dataOut_q   <= '0;
            dirtyOut_q  <= 1'b0;
        end else begin
            respValid_q <= req;
            if (req) begin
                hit_q      <= hit;
                way_q      <= tgtWay;
                tagOut_q   <= tagArr_q[addr_i][tgtWay];
                dataOut_q  <= cpuWriteHit ? mergedLine : oldLine;
                dirtyOut_q <= dirty_q[addr_i][tgtWay];
            end
        end
    end

    // Two matching ways means the controller allocated a duplicate tag.
    assert property (@(posedge clk_i) disable iff (!rst_ni) req |-> $onehot0(hitVec));

    assign busy_o       = (state_q == SWEEP);
    assign resp_valid_o = respValid_q;
    assign hit_o        = hit_q;
    assign way_o        = way_q;
    assign tag_o        = tagOut_q;
    assign data_o       = dataOut_q;
    assign dirty_o      = dirtyOut_q;

endmodule
